// File: rtl/arq_tx_ctrl_if.sv
// arq_tx_ctrl_if: host-side nibble handshake plus core-side write/response
// signals for the ARQ sender, with status and debug outputs.
//
// Handshake (src_valid/src_ready): a nibble transfers on a rising clk edge
// where both src_valid and src_ready are high; src_data must be stable while
// src_valid is high; src_ready is high only while the sender is idle and is
// a pure decode of state (never depends on src_valid).
interface arq_tx_ctrl_if;
  logic       src_valid;
  logic [3:0] src_data;
  logic       src_ready;
  logic       ack;
  logic       nack;
  logic       wr_en;
  logic [3:0] data_out;
  logic       busy;
  logic       tx_done;
  logic       tx_fail;
  logic [2:0] retry_cnt;
  logic [7:0] stat_retries;
  logic [7:0] stat_fails;
  logic [1:0] dbg_state;

  // DUT view
  modport slave (
    input  src_valid, src_data, ack, nack,
    output src_ready, wr_en, data_out, busy, tx_done, tx_fail,
           retry_cnt, stat_retries, stat_fails, dbg_state
  );

  // Host/core model view
  modport master (
    output src_valid, src_data, ack, nack,
    input  src_ready, wr_en, data_out, busy, tx_done, tx_fail,
           retry_cnt, stat_retries, stat_fails, dbg_state
  );
endinterface

// File: rtl/arq_tx_ctrl.sv
// arq_tx_ctrl: ARQ sender. Takes one nibble from the host, strobes it into
// the core, waits for ack/nack and retransmits on nack or timeout until
// MAX_RETRY retransmissions have been used, then pulses tx_done or tx_fail.
// Optional statistics counters are built only when ARQ_STATS_EN is defined;
// otherwise stat_retries/stat_fails are tied to zero.
module arq_tx_ctrl #(
  parameter int unsigned TIMEOUT   = 16,  // 2..255 cycles in WAIT
  parameter int unsigned MAX_RETRY = 3    // 0..7 retransmissions
) (
  input  logic          clk,
  input  logic          rst,
  arq_tx_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 1);
  localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

  state_t     state_q, state_d;
  logic       wr_en_q, wr_en_d;
  logic [3:0] data_out_q, data_out_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_fail_q, tx_fail_d;
  logic [2:0] retry_q, retry_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] hold_q, hold_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Registered outputs and datapath; reset clears everything so a reset
  // mid-transfer drops the held nibble and any pending strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q    <= 1'b0;
      data_out_q <= 4'd0;
      tx_done_q  <= 1'b0;
      tx_fail_q  <= 1'b0;
      retry_q    <= 3'd0;
      timer_q    <= 8'd0;
      hold_q     <= 4'd0;
    end else begin
      wr_en_q    <= wr_en_d;
      data_out_q <= data_out_d;
      tx_done_q  <= tx_done_d;
      tx_fail_q  <= tx_fail_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
    end
  end

  // Next-state and next-output decode. wr_en is registered, so it is
  // raised on the transition into SEND and is high for the SEND cycle.
  always_comb begin
    state_d    = state_q;
    wr_en_d    = 1'b0;
    data_out_d = data_out_q;
    tx_done_d  = 1'b0;
    tx_fail_d  = 1'b0;
    retry_d    = retry_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.src_valid) begin
          hold_d     = bus.src_data;
          data_out_d = bus.src_data;
          retry_d    = 3'd0;
          wr_en_d    = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        // Responses during the strobe cycle are ignored.
        timer_d = 8'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (bus.ack) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end else if (bus.nack || (timer_q == TIMER_LAST)) begin
          if (retry_q == RETRY_LIMIT) begin
            tx_fail_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            retry_d    = retry_q + 3'd1;
            data_out_d = hold_q;
            wr_en_d    = 1'b1;
            state_d    = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.src_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q == ST_SEND) || (state_q == ST_WAIT);
  assign bus.wr_en     = wr_en_q;
  assign bus.data_out  = data_out_q;
  assign bus.tx_done   = tx_done_q;
  assign bus.tx_fail   = tx_fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.dbg_state = state_q;

`ifdef ARQ_STATS_EN
  logic [7:0] stat_retries_q;
  logic [7:0] stat_fails_q;
  logic       retry_evt;

  assign retry_evt = (state_q == ST_WAIT) && (state_d == ST_SEND);

  // Saturating lifetime counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_retries_q <= 8'd0;
      stat_fails_q   <= 8'd0;
    end else begin
      if (retry_evt && (stat_retries_q != 8'hFF)) stat_retries_q <= stat_retries_q + 8'd1;
      if (tx_fail_d && (stat_fails_q != 8'hFF))   stat_fails_q   <= stat_fails_q + 8'd1;
    end
  end

  assign bus.stat_retries = stat_retries_q;
  assign bus.stat_fails   = stat_fails_q;
`else
  assign bus.stat_retries = 8'd0;
  assign bus.stat_fails   = 8'd0;
`endif

endmodule
